// File: rtl/serial_logic_unit_32bit.sv
`default_nettype none
// ============================================================================
// Module  : serial_logic_unit_32bit
// Brief   : Bit-serial AND/OR/XOR/NOR unit, one bit per clock, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
module serial_logic_unit_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt;

    logic             bit_val;
    logic [WIDTH-1:0] acc_next;

    // The single 1-bit gate stage shared by every bit position.
    always_comb begin
        bit_val = 1'b0;
        case (op_q)
            2'b00:   bit_val = a_sh[0] & b_sh[0];
            2'b01:   bit_val = a_sh[0] | b_sh[0];
            2'b10:   bit_val = a_sh[0] ^ b_sh[0];
            default: bit_val = ~(a_sh[0] | b_sh[0]);
        endcase
    end

    assign acc_next = {bit_val, acc[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            op_q   <= 2'b00;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new request exactly like IDLE for back-to-back use.
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        op_q  <= op;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc  <= acc_next;
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_CNT) begin
                        result <= acc_next;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_serial_logic_unit_32bit.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_logic_unit_32bit
// Brief   : Self-checking bench for serial_logic_unit_32bit against a word-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_logic_unit_32bit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    serial_logic_unit_32bit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [1:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Launch one operation, optionally pulse start mid-RUN, and check busy length, result and done pulse.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit poke_in_run);
        logic [WIDTH-1:0] exp_res;
        logic [WIDTH-1:0] prev_res;
        int busy_cnt;
        int n;
        exp_res  = model(o, a, b);
        @(negedge clk);
        prev_res = result;
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = $urandom(); A = $urandom(); B = $urandom();
        busy_cnt = 0;
        n = 0;
        while (!done && n < WIDTH + 8) begin
            if (busy) busy_cnt++;
            if (result !== prev_res) begin
                checks++; failures++;
                $display("FAIL %s result_changed_early got=%h want=%h", name, result, prev_res);
            end
            if (poke_in_run && n == 5) begin
                start = 1'b1; op = ~o; A = ~a; B = ~b;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout got=%b want=1", name, done);
        end
        checks++;
        if (busy_cnt !== WIDTH) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cnt, WIDTH);
        end
        checks++;
        if (result !== exp_res) begin
            failures++;
            $display("FAIL %s result got=%h want=%h", name, result, exp_res);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
            failures++;
            $display("FAIL %s after_done got done=%b busy=%b res=%h want done=0 busy=0 res=%h",
                     name, done, busy, result, exp_res);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got res=%h busy=%b done=%b want 0/0/0", result, busy, done);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        run_op("or_f0f0",   2'b01, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0);
        run_op("and_ffff",  2'b00, 32'hFFFF0000, 32'h12345678, 1'b0);
        run_op("xor_aaaa",  2'b10, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0);
        run_op("nor_zero",  2'b11, 32'h00000000, 32'h00000000, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            run_op("random", 2'($urandom_range(0, 3)), $urandom(), $urandom(), (i % 4) == 0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = 2'b01; A = 32'h1; B = 32'h2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < WIDTH + 8) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== 32'h3) begin
            failures++;
            $display("FAIL b2b_first got done=%b busy=%b res=%h want 1/0/00000003", done, busy, result);
        end
        start = 1'b1; op = 2'b00; A = 32'hFF; B = 32'h0F;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart got busy=%b done=%b want 1/0", busy, done);
        end
        busy_cnt = 0;
        n = 0;
        while (!done && n < WIDTH + 8) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || busy_cnt !== WIDTH || result !== 32'h0000000F) begin
            failures++;
            $display("FAIL b2b_second got done=%b busy_cycles=%0d res=%h want 1/%0d/0000000f",
                     done, busy_cnt, result, WIDTH);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        run_op("pre_reset", 2'b01, 32'h1, 32'h2, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b10; A = $urandom(); B = $urandom();
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || result !== 32'h3) begin
            failures++;
            $display("FAIL midrst_pre got busy=%b res=%h want 1/00000003", busy, result);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_async got res=%h busy=%b done=%b want 0/0/0", result, busy, done);
        end
        @(negedge clk);
        // Start rises together with reset release; first clean edge must accept it.
        reset = 1'b0;
        start = 1'b1; op = 2'b01; A = 32'h80000000; B = 32'h1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_accept got busy=%b want 1", busy);
        end
        repeat (WIDTH) @(negedge clk);
        checks++;
        if (done !== 1'b1 || result !== 32'h80000001) begin
            failures++;
            $display("FAIL midrst_after got done=%b res=%h want 1/80000001", done, result);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
